// File: rtl/bus_pkg.sv
// Shared encodings and defaults for the two-master bus arbiter.
package bus_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles of an outstanding bus transaction; expired marks the final
// allowed cycle (count == TIMEOUT-1).
module bus_timeout_counter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter onto one busy/ack bus,
// with timeout-to-error. Define BUS_ARBITER_ROUND_ROBIN_EN for alternating priority.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_stall,
  input  logic        d_rreq,
  input  logic        d_wreq,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        bus_err,
  output logic        bus_rreq,
  output logic        bus_wreq,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  input  logic        bus_ack
);

  logic [1:0]  state;
  logic        owner_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        d_pend;
  logic        grant_d;
  logic        active;
  logic        expired;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic last_owner;
`endif

  always_comb begin
    d_pend = d_rreq | d_wreq;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    // On a tie, data wins only if instruction was served last.
    grant_d = d_pend && (!i_req || (last_owner == OWN_I));
`else
    grant_d = d_pend;
`endif
  end

  assign active = (state == ISSUE) || (state == WAIT);

  bus_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!active),
    .enable  (active),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner_q <= OWN_I;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      last_owner <= OWN_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_pend || i_req) begin
            owner_q <= grant_d ? OWN_D : OWN_I;
            write_q <= grant_d && d_wreq;
            addr_q  <= grant_d ? d_addr : i_addr;
            wdata_q <= grant_d ? d_wdata : '0;
            err_q   <= 1'b0;
            state   <= ISSUE;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            last_owner <= grant_d ? OWN_D : OWN_I;
`endif
          end
        end
        ISSUE: begin
          if (write_q && bus_ack && !bus_busy) begin
            state <= DONE;
          end else if (!write_q && bus_ack) begin
            state <= WAIT;
          end else if (expired) begin
            err_q <= 1'b1;
            state <= DONE;
            if (!write_q) begin
              if (owner_q == OWN_D) d_rdata <= ERR_DATA;
              else                  i_rdata <= ERR_DATA;
            end
          end
        end
        WAIT: begin
          if (bus_ack && !bus_busy) begin
            state <= DONE;
            if (owner_q == OWN_D) d_rdata <= bus_rdata;
            else                  i_rdata <= bus_rdata;
          end else if (expired) begin
            err_q <= 1'b1;
            state <= DONE;
            if (owner_q == OWN_D) d_rdata <= ERR_DATA;
            else                  i_rdata <= ERR_DATA;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus_rreq  = !write_q && active;
  assign bus_wreq  = write_q && (state == ISSUE);
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign i_stall   = !((state == DONE) && (owner_q == OWN_I));
  assign d_stall   = !((state == DONE) && (owner_q == OWN_D));
  assign bus_err   = (state == DONE) && err_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, single-slave-bus arbiter directly upstream of the word-addressed memory/device bus (rreq/wreq/addr/wdata in; rdata/busy/ack out).
- Merges the CPU instruction-fetch port and load/store port onto one bus.
- Sequences each transaction through the bus busy/ack handshake and stalls the losing or waiting master.
- Converts missing acks (unmapped address) into a bus-error response after a timeout.

Parameters:
- TIMEOUT, 16: cycles without ack before a transaction ends in error; legal range 2..255.
- ERR_DATA, 32'hDEADBEEF: value returned on the read data port of an errored read.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request; held until i_stall=0
- i_addr  in  32  instruction byte address; held stable with i_req
- i_rdata  out  32  instruction read data; valid when i_req=1 and i_stall=0
- i_stall  out  1  instruction port must hold its request
- d_rreq  in  1  data read request
- d_wreq  in  1  data write request; d_rreq and d_wreq never both high
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_rdata  out  32  data read data; valid when d_rreq=1 and d_stall=0
- d_stall  out  1  data port must hold its request
- bus_err  out  1  one-cycle pulse, coincident with the completing stall=0 of an errored transaction
- bus_rreq, bus_wreq  out  1  bus read/write strobes
- bus_addr, bus_wdata  out  32  bus address and write data
- bus_rdata  in  32  bus read data (ORed from all devices)
- bus_busy  in  1  device busy
- bus_ack  in  1  some device claims the address

Behaviour:
Reset (async, reset_n=0):
- State IDLE, timeout counter 0.
- bus_rreq=bus_wreq=0; bus_addr=bus_wdata=0.
- i_stall=d_stall=1 while reset_n=0; i_rdata=d_rdata=0; bus_err=0.

State machine (states IDLE, ISSUE, WAIT, DONE):
- IDLE: pick a grant from pending requests.
  - Default: data port has fixed priority.
  - Latch owner, direction and address/wdata into registers; go to ISSUE.
  - Both stall outputs stay 1.
- ISSUE: drive the bus from the latched registers for exactly one cycle.
  - Write with bus_ack=1 and bus_busy=0: complete; go to DONE.
  - Read with bus_ack=1: go to WAIT.
  - bus_ack=0: increment the counter; stay in ISSUE.
  - Counter reaching TIMEOUT-1: error; go to DONE.
- WAIT: keep the bus strobe asserted.
  - First cycle with bus_busy=0 and bus_ack=1: capture bus_rdata into the owner's rdata register; go to DONE.
  - Counter keeps running in WAIT; the same timeout rule applies.
- DONE: drive the owner's stall=0 for one cycle, plus bus_err if errored.
  - Bus strobes are 0 in DONE.
  - Return to IDLE; the counter clears.

Timing and latency:
- Nominal internal-memory read: 4 cycles from request to stall=0 (IDLE, ISSUE, WAIT with busy, DONE).
- Write: 3 cycles.

Request rules:
- Rdata outputs hold their last captured value until the next capture.
- A request dropped before completion is a master protocol violation; the arbiter still completes the transaction and discards the result.
- Requests arriving during a transaction wait and are evaluated only in IDLE.
- Back-to-back transactions from the same master are legal; each takes a full pass through IDLE.

Errors:
- Errored read returns ERR_DATA.
- Errored write has no side effect.

Optional Feature:
- Macro BUS_ARBITER_ROUND_ROBIN_EN.
- Defined: a 1-bit last-owner register (reset to instruction) flips priority when both ports request in IDLE, so the port not served last wins.
- Undefined: data port always wins simultaneous requests; an instruction request can starve while d_rreq/d_wreq stay asserted.

Decomposition:
- Shared package bus_pkg:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3)
  - owner encoding (OWN_I=1'b0, OWN_D=1'b1)
  - default ERR_DATA constant
- One natural sub-module, bus_timeout_counter: clear/enable inputs, expired output, TIMEOUT parameter.

Test Plan:
- d_rreq only, addr=32'h10, device acks with busy pulse on cycle 2 and bus_rdata=32'h12345678 -> d_stall=0 on cycle 4, d_rdata=32'h12345678, bus_err=0.
- d_wreq only, addr=32'h20, wdata=32'hA5A5A5A5, ack=1, busy=0 -> one bus_wreq cycle carrying those values; d_stall=0 on cycle 3.
- i_req and d_rreq together, feature off -> data served first, instruction completes 4 cycles later.
- Same stimulus with the feature on, last owner = D -> instruction served first.
- d_rreq to addr=32'hFFFF0000, bus_ack held 0, TIMEOUT=16 -> d_stall=0 with bus_err=1 and d_rdata=32'hDEADBEEF; bus_rreq deasserted afterwards.
- reset_n pulsed low while in WAIT -> all outputs immediately at reset values; a fresh i_req after release completes normally.
